mantissa_align_shifter: RTL and testbench

Serial right-shift alignment stage for the floating-point adder datapath. It compares two operand exponents, swaps operands so the larger exponent leads, and shifts the smaller mantissa right one bit per clock, with guard, round and sticky bits, until it is aligned. It feeds the adder and normaliser, and also outputs the clamped 5-bit shift amount that the downstream shift-control counter uses as its limiter.

---
 rtl/mantissa_align_shifter.sv | 164 ++++++++++++++++
 tb/tb_mantissa_align_shifter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_align_shifter.sv
// Serial alignment stage for the FP adder: orders operands by exponent and shifts the
// smaller mantissa right one bit per clock, keeping guard, round and sticky bits.
module mantissa_align_shifter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int CNT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    input  logic [MAN_W-1:0]   man_a,
    input  logic [MAN_W-1:0]   man_b,
    output logic               busy,
    output logic               done,
    output logic               swapped,
    output logic [EXP_W-1:0]   exp_out,
    output logic [CNT_W-1:0]   shift_amt,
    output logic [MAN_W+2:0]   man_large,
    output logic [MAN_W+2:0]   man_small
);

    localparam int EXT_W = MAN_W + 3;
    localparam logic [EXP_W:0]   LIM_DIFF = (EXP_W + 1)'(EXT_W);
    localparam logic [CNT_W-1:0] LIM_CNT  = CNT_W'(EXT_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic               swap_s;
    logic [EXP_W:0]     diff_s;
    logic [CNT_W-1:0]   shift_n_s;
    logic [EXP_W-1:0]   exp_big_s;
    logic [MAN_W-1:0]   man_big_s;
    logic [MAN_W-1:0]   man_lit_s;

    logic               busy_r;
    logic               done_r;
    logic               swapped_r;
    logic [EXP_W-1:0]   exp_out_r;
    logic [CNT_W-1:0]   shift_amt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [EXT_W-1:0]   man_large_r;
    logic [EXT_W-1:0]   man_small_r;

    // One alignment step: bits leaving bit 0 are ORed into the sticky position.
    function automatic logic [EXT_W-1:0] sticky_shr(input logic [EXT_W-1:0] v);
        return {1'b0, v[EXT_W-1:2], v[1] | v[0]};
    endfunction

    // Operand ordering, exponent difference and clamped shift count for a new request.
    always_comb begin
        swap_s    = (exp_b > exp_a);
        diff_s    = '0;
        exp_big_s = exp_a;
        man_big_s = man_a;
        man_lit_s = man_b;
        if (swap_s) begin
            diff_s    = {1'b0, exp_b} - {1'b0, exp_a};
            exp_big_s = exp_b;
            man_big_s = man_b;
            man_lit_s = man_a;
        end else begin
            diff_s    = {1'b0, exp_a} - {1'b0, exp_b};
            exp_big_s = exp_a;
            man_big_s = man_a;
            man_lit_s = man_b;
        end
        if (diff_s > LIM_DIFF) begin
            shift_n_s = LIM_CNT;
        end else begin
            shift_n_s = diff_s[CNT_W-1:0];
        end
    end

    // Next-state logic; the counter holds shifts still to do, so 1 means this is the last.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (shift_n_s == '0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r <= CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus the status flags derived from the upcoming state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: load on an accepted request, shift while in SHIFT, otherwise hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            swapped_r   <= 1'b0;
            exp_out_r   <= '0;
            shift_amt_r <= '0;
            cnt_r       <= '0;
            man_large_r <= '0;
            man_small_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        swapped_r   <= swap_s;
                        exp_out_r   <= exp_big_s;
                        shift_amt_r <= shift_n_s;
                        cnt_r       <= shift_n_s;
                        man_large_r <= {man_big_s, 3'b000};
                        man_small_r <= {man_lit_s, 3'b000};
                    end
                end
                ST_SHIFT: begin
                    man_small_r <= sticky_shr(man_small_r);
                    cnt_r       <= cnt_r - CNT_ONE;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign swapped   = swapped_r;
    assign exp_out   = exp_out_r;
    assign shift_amt = shift_amt_r;
    assign man_large = man_large_r;
    assign man_small = man_small_r;

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// Self-checking bench for mantissa_align_shifter: vector table and random operands feed a
// scoreboard that is checked whenever done pulses, plus busy/reset corner sequences.
module tb_mantissa_align_shifter;

    typedef struct {
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        sw;
        logic [7:0]  eo;
        logic [4:0]  n;
        logic [26:0] lg;
        logic [26:0] sm;
    } vec_t;

    typedef struct {
        vec_t v;
        int   dcyc;
    } sb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  exp_a = 8'd0;
    logic [7:0]  exp_b = 8'd0;
    logic [23:0] man_a = 24'd0;
    logic [23:0] man_b = 24'd0;
    logic        busy;
    logic        done;
    logic        swapped;
    logic [7:0]  exp_out;
    logic [4:0]  shift_amt;
    logic [26:0] man_large;
    logic [26:0] man_small;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    sb_t  sb[$];
    vec_t tbl[9];

    mantissa_align_shifter dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .man_a     (man_a),
        .man_b     (man_b),
        .busy      (busy),
        .done      (done),
        .swapped   (swapped),
        .exp_out   (exp_out),
        .shift_amt (shift_amt),
        .man_large (man_large),
        .man_small (man_small)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endfunction

    // Reference: sticky = OR of every bit shifted out, computed in one step.
    function automatic vec_t model(logic [7:0] ea, logic [7:0] eb, logic [23:0] ma, logic [23:0] mb);
        vec_t        v;
        logic [8:0]  d;
        logic [63:0] ext;
        logic [63:0] mask;
        logic [63:0] res;
        v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb;
        v.sw = (eb > ea);
        d    = v.sw ? ({1'b0, eb} - {1'b0, ea}) : ({1'b0, ea} - {1'b0, eb});
        v.n  = (d > 9'd27) ? 5'd27 : d[4:0];
        v.eo = v.sw ? eb : ea;
        v.lg = {(v.sw ? mb : ma), 3'b000};
        ext  = {37'd0, (v.sw ? ma : mb), 3'b000};
        mask = (64'd1 << v.n) - 64'd1;
        res  = (ext >> v.n) | {63'd0, ((ext & mask) != 64'd0)};
        v.sm = res[26:0];
        return v;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done) begin
            sb_t e;
            done_cnt++;
            chk("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.dcyc));
                chk("swapped", 64'(swapped), 64'(e.v.sw));
                chk("exp_out", 64'(exp_out), 64'(e.v.eo));
                chk("shift_amt", 64'(shift_amt), 64'(e.v.n));
                chk("man_large", 64'(man_large), 64'(e.v.lg));
                chk("man_small", 64'(man_small), 64'(e.v.sm));
            end
        end
    end

    task automatic drive(input vec_t v, input logic push);
        @(negedge clock);
        exp_a = v.ea; exp_b = v.eb; man_a = v.ma; man_b = v.mb;
        start = 1'b1;
        if (push) begin
            sb.push_back('{v: v, dcyc: cyc + 1 + int'(v.n)});
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        drive(v, 1'b1);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clock);
        chk("done_seen", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_swapped"}, 64'(swapped), 64'd0);
        chk({tag, "_exp_out"}, 64'(exp_out), 64'd0);
        chk({tag, "_shift_amt"}, 64'(shift_amt), 64'd0);
        chk({tag, "_man_large"}, 64'(man_large), 64'd0);
        chk({tag, "_man_small"}, 64'(man_small), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t w;
        int   dc;
        tbl[0] = '{8'd130, 8'd128, 24'h800000, 24'hC00000, 1'b0, 8'd130, 5'd2,  27'h4000000, 27'h1800000};
        tbl[1] = '{8'd127, 8'd127, 24'h123456, 24'hABCDEF, 1'b0, 8'd127, 5'd0,  27'h091A2B0, 27'h55E6F78};
        tbl[2] = '{8'd100, 8'd150, 24'h800000, 24'hFFFFFF, 1'b1, 8'd150, 5'd27, 27'h7FFFFF8, 27'h0000001};
        tbl[3] = '{8'd131, 8'd126, 24'h900000, 24'h800001, 1'b0, 8'd131, 5'd5,  27'h4800000, 27'h0200001};
        tbl[4] = '{8'd0,   8'd255, 24'h000000, 24'h800000, 1'b1, 8'd255, 5'd27, 27'h4000000, 27'h0000000};
        tbl[5] = '{8'd27,  8'd0,   24'hFFFFFF, 24'hFFFFFF, 1'b0, 8'd27,  5'd27, 27'h7FFFFF8, 27'h0000001};
        tbl[6] = '{8'd10,  8'd35,  24'hC00000, 24'h000001, 1'b1, 8'd35,  5'd25, 27'h0000008, 27'h0000003};
        tbl[7] = '{8'd228, 8'd200, 24'h000001, 24'h000002, 1'b0, 8'd228, 5'd27, 27'h0000008, 27'h0000001};
        tbl[8] = '{8'd5,   8'd6,   24'h000003, 24'hFFFFFF, 1'b1, 8'd6,   5'd1,  27'h7FFFFF8, 27'h000000C};

        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                v = model(8'($urandom_range(110, 140)), 8'($urandom_range(110, 140)),
                          24'($urandom), 24'($urandom));
            end else begin
                v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          24'($urandom), 24'($urandom));
            end
            apply(v);
        end

        // Starts during SHIFT and during the done cycle must both be ignored.
        dc = done_cnt;
        w  = tbl[0];
        drive(tbl[2], 1'b1);
        repeat (5) @(negedge clock);
        drive(w, 1'b0);
        for (int i = 0; i < 64 && !done; i++) @(negedge clock);
        chk("busy_seq_done_seen", 64'(done), 64'd1);
        exp_a = w.ea; exp_b = w.eb; man_a = w.ma; man_b = w.mb;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_seq_idle", 64'(busy), 64'd0);
        repeat (5) @(negedge clock);
        chk("busy_seq_still_idle", 64'(busy), 64'd0);
        chk("busy_seq_one_done", 64'(done_cnt - dc), 64'd1);
        chk("busy_seq_exp_out", 64'(exp_out), 64'd150);
        chk("busy_seq_man_small", 64'(man_small), 64'h1);
        chk("busy_seq_shift_amt", 64'(shift_amt), 64'd27);
        chk("busy_seq_swapped", 64'(swapped), 64'd1);
        sb.delete();

        // Reset in the middle of a long shift aborts it without a done pulse.
        dc = done_cnt;
        drive(tbl[2], 1'b1);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        check_zero("midreset");
        repeat (35) @(negedge clock);
        chk("midreset_no_done", 64'(done_cnt - dc), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        apply(tbl[3]);
        apply(tbl[0]);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
